// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/EXEC/MEM/WB/TRAP with separate fetch, load and store handshakes.
// Define MCPU_PERF_CNT_EN to build the cycle/retire performance counters.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module multicycle_cpu #(
  parameter int             W        = `WORD_WIDTH,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [W-1:0]  pc,
  output logic          inst_req,
  input  logic [31:0]   inst,
  input  logic          inst_ack,
  output logic          load_en,
  output logic [W-1:0]  l_addr,
  input  logic [W-1:0]  l_data,
  input  logic          l_ack,
  output logic          store_en,
  output logic [W-1:0]  s_addr,
  output logic [W-1:0]  s_data,
  input  logic          s_ack,
  output logic          halted,
  output logic [W-1:0]  cycle_cnt,
  output logic [W-1:0]  retire_cnt
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, TRAP} state_t;

  state_t       state, state_nx;
  logic [31:0]  ir;
  logic [W-1:0] rf [32];
  logic [W-1:0] res_q, npc_q, addr_q, sdat_q;
  logic [4:0]   dst_q;
  logic         wen_q, is_ld_q;

  logic [5:0]   op, funct;
  logic [4:0]   rs, rt, rd, shamt, dst;
  logic [15:0]  imm;
  logic [W-1:0] a, b, simm, zimm, pc4, alu, npc, ea;
  logic         wen, is_mem, is_ld, trap;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  assign a    = (rs == 5'd0) ? '0 : rf[rs];
  assign b    = (rt == 5'd0) ? '0 : rf[rt];
  assign simm = {{(W-16){imm[15]}}, imm};
  assign zimm = {{(W-16){1'b0}}, imm};
  assign pc4  = pc + W'(4);

  // Decode/execute: everything EXEC needs is derived from the latched instruction.
  always_comb begin
    alu    = '0;
    wen    = 1'b0;
    dst    = rt;
    is_mem = 1'b0;
    is_ld  = 1'b0;
    trap   = 1'b0;
    npc    = pc4;
    ea     = a + simm;
    case (op)
      6'h00: begin
        dst = rd;
        wen = 1'b1;
        case (funct)
          6'h21:   alu = a + b;
          6'h23:   alu = a - b;
          6'h24:   alu = a & b;
          6'h25:   alu = a | b;
          6'h26:   alu = a ^ b;
          6'h2a:   alu = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
          6'h00:   alu = b << shamt;
          6'h02:   alu = b >> shamt;
          default: begin
            wen  = 1'b0;
            trap = 1'b1;
          end
        endcase
      end
      6'h09: begin alu = a + simm;  wen = 1'b1; end
      6'h0c: begin alu = a & zimm;  wen = 1'b1; end
      6'h0d: begin alu = a | zimm;  wen = 1'b1; end
      6'h0f: begin alu = zimm << 16; wen = 1'b1; end
      6'h23: begin is_mem = 1'b1; is_ld = 1'b1; wen = 1'b1; end
      6'h2b: is_mem = 1'b1;
      6'h04: if (a == b) npc = pc4 + (simm << 2);
      6'h05: if (a != b) npc = pc4 + (simm << 2);
      6'h02: npc[27:0] = {ir[25:0], 2'b00};
      default: trap = 1'b1;
    endcase
    // Misaligned accesses trap from EXEC so MEM never raises a strobe for them.
    if (is_mem && ea[1:0] != 2'b00) trap = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (inst_ack) state_nx = EXEC;
      EXEC:    state_nx = trap ? TRAP : (is_mem ? MEM : WB);
      MEM:     if (is_ld_q ? l_ack : s_ack) state_nx = WB;
      WB:      state_nx = FETCH;
      default: state_nx = TRAP;
    endcase
  end

  // Strobes are masked by rst so nothing is requested while reset is held.
  assign inst_req = !rst && state == FETCH;
  assign load_en  = !rst && state == MEM && is_ld_q;
  assign store_en = !rst && state == MEM && !is_ld_q;
  assign halted   = state == TRAP;
  assign l_addr   = addr_q;
  assign s_addr   = addr_q;
  assign s_data   = sdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      addr_q  <= '0;
      sdat_q  <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
      is_ld_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH: if (inst_ack) ir <= inst;
        EXEC: begin
          res_q   <= alu;
          npc_q   <= npc;
          addr_q  <= ea;
          sdat_q  <= b;
          dst_q   <= dst;
          wen_q   <= wen && dst != 5'd0;
          is_ld_q <= is_ld;
        end
        MEM: if (is_ld_q && l_ack) res_q <= l_data;
        WB: begin
          if (wen_q) rf[dst_q] <= res_q;
          pc <= npc_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MCPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != TRAP) cycle_cnt  <= cycle_cnt + W'(1);
      if (state == WB)   retire_cnt <= retire_cnt + W'(1);
    end
  end
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: table of small programs ending in a trap, plus reset/branch/abort sequences.
`timescale 1ns/1ps
module tb_multicycle_cpu;
  localparam int W = 32;
  localparam logic [31:0] TRAP_I = 32'hFC00_0000;
  localparam int ADDIU = 'h09, ANDI = 'h0c, ORI = 'h0d, LUI = 'h0f, LW = 'h23, SW = 'h2b,
                 BEQ = 'h04, BNE = 'h05;
  localparam int F_ADDU = 'h21, F_SUBU = 'h23, F_AND = 'h24, F_OR = 'h25, F_XOR = 'h26,
                 F_SLT = 'h2a, F_SLL = 'h00, F_SRL = 'h02;

  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] pc, l_addr, s_addr, s_data, cycle_cnt, retire_cnt;
  logic [W-1:0] l_data = '0;
  logic [31:0]  inst = '0;
  logic inst_req, load_en, store_en, halted;
  logic inst_ack = 1'b0, l_ack = 1'b0, s_ack = 1'b0;

  multicycle_cpu #(.W(W), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_req(inst_req), .inst(inst), .inst_ack(inst_ack),
    .load_en(load_en), .l_addr(l_addr), .l_data(l_data), .l_ack(l_ack),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .s_ack(s_ack),
    .halted(halted), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));

  always #5 clk = ~clk;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  int  idly = 0, mdly = 0;
  bit  force_ack = 1'b0;
  int  icnt = 0, mcnt = 0, hold = 0, last_hold = 0;
  int  nstores = 0, ld_cnt = 0, onehot_bad = 0, unstable = 0;
  logic [31:0] last_saddr = '0, last_sdata = '0, first_a = '0, first_d = '0;
  logic [31:0] fetch_log [$];
  int n_cmp = 0, n_bad = 0;

  // Memory responder and monitor: decides acks for the coming edge and logs completed transfers.
  always @(negedge clk) begin
    if (int'(inst_req) + int'(load_en) + int'(store_en) > 1) onehot_bad++;
    if (load_en) ld_cnt++;
    if (rst) for (int k = 0; k < 16; k++) dmem[k] = '0;
    inst_ack = 1'b0;
    l_ack    = force_ack;
    s_ack    = force_ack;
    if (inst_req) begin
      if (icnt >= idly) begin
        inst_ack = 1'b1;
        inst = imem[pc[5:2]];
        fetch_log.push_back(pc);
        icnt = 0;
      end else icnt++;
    end else icnt = 0;
    if (load_en || store_en) begin
      hold++;
      if (hold == 1) begin
        first_a = store_en ? s_addr : l_addr;
        first_d = s_data;
      end else if ((store_en ? s_addr : l_addr) != first_a || (store_en && s_data != first_d))
        unstable++;
      if (mcnt >= mdly) begin
        mcnt = 0;
        if (load_en) begin
          l_ack  = 1'b1;
          l_data = dmem[l_addr[5:2]];
        end else begin
          s_ack = 1'b1;
          dmem[s_addr[5:2]] = s_data;
          last_saddr = s_addr;
          last_sdata = s_data;
          nstores++;
          last_hold = hold;
        end
        hold = 0;
      end else mcnt++;
    end else begin
      mcnt = 0;
      hold = 0;
    end
  end

  function automatic logic [31:0] rr(int fn, int rd, int rs, int rt, int sh = 0);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] ii(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jj(int idx);
    return {6'h02, 26'(idx)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int base_nst = 0, base_ld = 0, base_fl = 0;

  task automatic do_reset(input bit check, input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (check) begin
      chk({tag, "_rst_inst_req"}, 32'(inst_req), 0);
      chk({tag, "_rst_strobes"}, 32'({load_en, store_en}), 0);
      chk({tag, "_rst_halted"}, 32'(halted), 0);
      chk({tag, "_rst_pc"}, pc, 0);
      chk({tag, "_rst_cnts"}, cycle_cnt | retire_cnt, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    base_nst = nstores;
    base_ld  = ld_cnt;
    base_fl  = fetch_log.size();
    #1;
    if (check) chk({tag, "_first_inst_req"}, 32'(inst_req), 1);
  endtask

  task automatic run_to_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #1;
      if (halted) ok = 1'b1;
    end
  endtask

  task automatic wait_fetches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #1;
      if (fetch_log.size() - base_fl >= n) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0][31:0] prog;
    int          idly, mdly;
    logic [31:0] exp_pc;
    int          exp_nst;
    logic [31:0] exp_sa, exp_sd;
    bit          exp_ld;
  } vec_t;
  localparam int NV = 11;
  vec_t vt [NV];

  function automatic void setv(int v, int id, int md, logic [31:0] epc, int nst,
                               logic [31:0] sa, logic [31:0] sd, bit ld,
                               logic [31:0] i0, logic [31:0] i1 = TRAP_I, logic [31:0] i2 = TRAP_I,
                               logic [31:0] i3 = TRAP_I, logic [31:0] i4 = TRAP_I,
                               logic [31:0] i5 = TRAP_I, logic [31:0] i6 = TRAP_I,
                               logic [31:0] i7 = TRAP_I);
    vt[v].prog = {i7, i6, i5, i4, i3, i2, i1, i0};
    vt[v].idly = id;  vt[v].mdly = md;  vt[v].exp_pc = epc;  vt[v].exp_nst = nst;
    vt[v].exp_sa = sa;  vt[v].exp_sd = sd;  vt[v].exp_ld = ld;
  endfunction

  initial begin
    bit ok;
    for (int k = 0; k < 16; k++) imem[k] = TRAP_I;

    setv(0, 0, 0, 32'h0c, 1, 4, 32'hFFFF_FFFE, 0,
         ii(ADDIU, 1, 0, 5), ii(ADDIU, 2, 1, -7), ii(SW, 2, 0, 4));
    setv(1, 2, 0, 32'h14, 1, 8, 32'hFFFF_FFFF, 0,
         ii(ADDIU, 1, 0, -3), ii(ADDIU, 2, 0, 2), rr(F_SLT, 3, 1, 2), rr(F_SUBU, 4, 3, 2),
         ii(SW, 4, 0, 8));
    setv(2, 0, 0, 32'h14, 1, 12, 32'h1234_0065, 0,
         ii(LUI, 1, 0, 'h1234), ii(ORI, 1, 1, 'h8765), ii(ANDI, 2, 1, 'hFF00),
         rr(F_XOR, 3, 1, 2), ii(SW, 3, 0, 12));
    setv(3, 0, 1, 32'h1c, 1, 16, 32'h0000_0F0F, 0,
         ii(ADDIU, 1, 0, 240), rr(F_SLL, 2, 0, 1, 4), rr(F_SRL, 3, 0, 2, 8), rr(F_AND, 4, 2, 1),
         rr(F_OR, 5, 3, 2), rr(F_ADDU, 6, 5, 4), ii(SW, 6, 0, 16));
    setv(4, 0, 0, 32'h0c, 1, 20, 32'h0, 0,
         ii(ADDIU, 0, 0, 9), rr(F_ADDU, 4, 0, 0), ii(SW, 4, 0, 20));
    setv(5, 0, 0, 32'h14, 1, 0, 32'h1, 0,
         ii(ADDIU, 1, 0, 1), ii(BNE, 0, 1, 2), ii(ADDIU, 1, 0, 7), TRAP_I, ii(SW, 1, 0, 0));
    setv(6, 1, 0, 32'h18, 1, 32'h24, 32'h55, 0,
         jj(4), TRAP_I, TRAP_I, TRAP_I, ii(ADDIU, 2, 0, 'h55), ii(SW, 2, 0, 'h24));
    setv(7, 0, 0, 32'h0, 0, 0, 0, 0, ii(LW, 1, 0, 2));
    setv(8, 0, 0, 32'h4, 0, 0, 0, 0, ii(ADDIU, 1, 0, 3), ii(SW, 1, 0, 1));
    setv(9, 1, 3, 32'h14, 2, 8, 32'hFFFF_FFFF, 1,
         ii(ADDIU, 1, 0, -2), ii(SW, 1, 0, 4), ii(LW, 3, 0, 4), ii(ADDIU, 3, 3, 1),
         ii(SW, 3, 0, 8));
    setv(10, 0, 0, 32'h0, 0, 0, 0, 0, rr('h20, 1, 0, 0));

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < 16; k++) imem[k] = (k < 8) ? vt[v].prog[k] : TRAP_I;
      idly = vt[v].idly;
      mdly = vt[v].mdly;
      do_reset(v == 0, $sformatf("v%0d", v));
      run_to_halt(400, ok);
      chk($sformatf("v%0d_halt", v), 32'(ok), 1);
      chk($sformatf("v%0d_pc", v), pc, vt[v].exp_pc);
      chk($sformatf("v%0d_nstores", v), 32'(nstores - base_nst), 32'(vt[v].exp_nst));
      chk($sformatf("v%0d_load_seen", v), 32'(ld_cnt != base_ld), 32'(vt[v].exp_ld));
      if (vt[v].exp_nst > 0) begin
        chk($sformatf("v%0d_s_addr", v), last_saddr, vt[v].exp_sa);
        chk($sformatf("v%0d_s_data", v), last_sdata, vt[v].exp_sd);
        chk($sformatf("v%0d_store_hold", v), 32'(last_hold), 32'(vt[v].mdly + 1));
      end
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d_frozen_pc", v), pc, vt[v].exp_pc);
      chk($sformatf("v%0d_trap_quiet", v), 32'({inst_req, load_en, store_en, halted}), 32'h1);
    end

    // Two ADDIUs with immediate acks: pc reaches 8 after exactly six cycles.
    for (int k = 0; k < 16; k++) imem[k] = (k < 8) ? vt[0].prog[k] : TRAP_I;
    idly = 0;
    mdly = 0;
    do_reset(1'b1, "lat");
    repeat (5) @(posedge clk);
    #1;
    chk("lat_pc_c5", pc, 32'h4);
    @(posedge clk);
    #1;
    chk("lat_pc_c6", pc, 32'h8);

    // Branch-to-self loop after four ALU instructions; also the perf counter point.
    for (int k = 0; k < 16; k++) imem[k] = (k < 4) ? 32'h2400_0000 : TRAP_I;
    imem[4] = ii(BEQ, 0, 0, -1);
    do_reset(1'b0, "beq");
    repeat (9) @(posedge clk);
    #1;
`ifdef MCPU_PERF_CNT_EN
    chk("perf_retire", retire_cnt, 32'd3);
    chk("perf_cycle", cycle_cnt, 32'd9);
`else
    chk("perf_retire_off", retire_cnt, 32'd0);
    chk("perf_cycle_off", cycle_cnt, 32'd0);
`endif
    wait_fetches(7, 100, ok);
    chk("beq_fetch_to", 32'(ok), 1);
    if (ok) begin
      chk("beq_f4", fetch_log[base_fl + 4], 32'h10);
      chk("beq_f5", fetch_log[base_fl + 5], 32'h10);
      chk("beq_f6", fetch_log[base_fl + 6], 32'h10);
    end
    chk("beq_not_halted", 32'(halted), 0);

    imem[4] = ii(BNE, 0, 0, 4);
    do_reset(1'b0, "bne");
    wait_fetches(6, 100, ok);
    chk("bne_fetch_to", 32'(ok), 1);
    if (ok) chk("bne_f5", fetch_log[base_fl + 5], 32'h14);

    // Reset in the middle of a stalled store, then acks held high afterwards.
    for (int k = 0; k < 16; k++) imem[k] = TRAP_I;
    imem[0] = ii(ADDIU, 1, 0, 1);
    imem[1] = ii(SW, 1, 0, 0);
    mdly = 60;
    do_reset(1'b0, "abort");
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (store_en) ok = 1'b1;
    end
    chk("abort_store_seen", 32'(ok), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_store_drop", 32'(store_en), 0);
    chk("abort_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mdly = 0;
    force_ack = 1'b1;
    base_nst = nstores;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pc_after_alu", pc, 32'h4);
    chk("abort_no_early_store", 32'(nstores - base_nst), 0);
    run_to_halt(50, ok);
    chk("abort_halt", 32'(ok), 1);
    chk("abort_final_pc", pc, 32'h8);
    chk("abort_store_once", 32'(nstores - base_nst), 1);
    chk("abort_store_data", last_sdata, 32'h1);
    force_ack = 1'b0;

    chk("strobe_onehot", 32'(onehot_bad), 0);
    chk("strobe_stable", 32'(unstable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
